// File: rtl/cl_decode_stage_pkg.sv
// Shared definitions for the decode stage: opcode patterns, instruction and
// decode records, stage state encoding, and the opcode-class decode function.
package cl_decode_stage_pkg;

   // Register fields in the instruction word are fixed-width; the stage
   // parameter RF_ADDR_W selects how many low bits address the register file.
   localparam int unsigned kInstrRegW = 6;

   typedef enum logic [5:0] {
      kADDU  = 6'd0,
      kSUBU  = 6'd1,
      kSLLV  = 6'd2,
      kSRAV  = 6'd3,
      kSRLV  = 6'd4,
      kAND   = 6'd5,
      kOR    = 6'd6,
      kNOR   = 6'd7,
      kSLT   = 6'd8,
      kSLTU  = 6'd9,
      kMOV   = 6'd10,
      kBAR   = 6'd11,
      kWAIT  = 6'd12,
      kBEQZ  = 6'd13,
      kBNEQZ = 6'd14,
      kBGTZ  = 6'd15,
      kBLTZ  = 6'd16,
      kJALR  = 6'd17,
      kLW    = 6'd18,
      kLBU   = 6'd19,
      kSW    = 6'd20,
      kSB    = 6'd21,
      kNOP   = 6'd22
   } opcode_e;

   typedef struct packed {
      opcode_e                opcode;
      logic [kInstrRegW-1:0]  rd;
      logic [kInstrRegW-1:0]  rs_imm;
   } instruction_s;

   typedef struct packed {
      logic                   is_load;
      logic                   op_writes_rf;
      logic                   is_store;
      logic                   is_mem;
      logic                   is_byte;
      logic [kInstrRegW-1:0]  rd;
      logic [kInstrRegW-1:0]  rs;
   } decode_s;

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } dec_state_e;

   // With byte ops disabled, LBU/SB lose their memory classification.
   function automatic decode_s decode_instr(input instruction_s instr,
                                            input logic byte_ops_en);
      decode_s d;
      d      = '0;
      d.rd   = instr.rd;
      d.rs   = instr.rs_imm;
      case (instr.opcode)
         kLW:  d.is_load = 1'b1;
         kLBU: begin
            d.is_load = byte_ops_en;
            d.is_byte = byte_ops_en;
         end
         kSW:  d.is_store = 1'b1;
         kSB:  begin
            d.is_store = byte_ops_en;
            d.is_byte  = byte_ops_en;
         end
         default: ;
      endcase
      d.is_mem = d.is_load | d.is_store;
      case (instr.opcode)
         kADDU, kSUBU, kSLLV, kSRAV, kSRLV, kAND, kOR, kNOR, kSLT, kSLTU,
         kMOV, kJALR, kLW, kLBU, kNOP: d.op_writes_rf = 1'b1;
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/cl_scoreboard.sv
// In-flight load tracker: one pending bit per register, a saturating count of
// outstanding loads, and a sticky error flag for bookkeeping violations.
module cl_scoreboard #(
   parameter int unsigned RF_ADDR_W   = 6,
   parameter int unsigned MAX_PENDING = 2
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                issue_v,
   input  logic [RF_ADDR_W-1:0]                issue_rd,
   input  logic                                retire_v,
   input  logic [RF_ADDR_W-1:0]                retire_rd,
   output logic [2**RF_ADDR_W-1:0]             pending,
   output logic [$clog2(MAX_PENDING+1)-1:0]    count,
   output logic                                retire_ok,
   output logic                                err
);

   localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);
   localparam int unsigned NREGS = 2**RF_ADDR_W;

   logic [NREGS-1:0]  pending_q, pending_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;

   assign retire_ok = retire_v && pending_q[retire_rd];

   // NOTE: every variable this block writes gets its default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      pending_d = pending_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      if (retire_v && !retire_ok) err_d = 1'b1;
      // Retire clears before issue sets, so a same-cycle reuse of rd ends set.
      if (retire_ok) pending_d[retire_rd] = 1'b0;
      if (issue_v)   pending_d[issue_rd]  = 1'b1;
      case ({issue_v, retire_ok})
         2'b10: begin
            if (cnt_q == CNT_W'(MAX_PENDING)) err_d = 1'b1;
            else                              cnt_d = cnt_q + CNT_W'(1);
         end
         2'b01: begin
            if (cnt_q == '0) err_d = 1'b1;
            else             cnt_d = cnt_q - CNT_W'(1);
         end
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   // NOTE: the pending vector is reset like any control flop: a stale bit would
   // stall the pipeline forever, so it cannot be left uninitialised like RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

   assign pending = pending_q;
   assign count   = cnt_q;
   assign err     = err_q;

endmodule

// File: rtl/cl_decode_stage.sv
// Registered decode stage with load-use hazard detection and a bounded count
// of loads in flight between hand-off and retire.
module cl_decode_stage
   import cl_decode_stage_pkg::*;
#(
   parameter int unsigned RF_ADDR_W   = 6,
   parameter int unsigned MAX_PENDING = 2,
   parameter int unsigned BYTE_OPS_EN = 1
) (
   input  logic                              clk,
   input  logic                              n_reset_i,
   input  logic                              instr_v_i,
   input  instruction_s                      instruction_i,
   output logic                              instr_ready_o,
   input  logic                              flush_i,
   output logic                              dec_v_o,
   input  logic                              dec_ready_i,
   output decode_s                           dec_o,
   input  logic                              load_done_v_i,
   input  logic [RF_ADDR_W-1:0]              load_done_rd_i,
   output logic [$clog2(MAX_PENDING+1)-1:0]  pending_cnt_o,
   output logic                              hazard_o,
   output logic                              err_o
);

   localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1);

   dec_state_e                state_q, state_d;
   decode_s                   dec_q;
   decode_s                   offered;
   logic                      full;
   logic                      accept;
   logic                      issue_v;
   logic                      retire_ok;
   logic                      cap_block;
   logic                      pend_hit;
   logic                      stage_hit;
   logic [2**RF_ADDR_W-1:0]   pending;
   logic [RF_ADDR_W-1:0]      off_rd, off_rs, held_rd;

   assign offered = decode_instr(instruction_i, BYTE_OPS_EN != 0);
   assign full    = (state_q == S_FULL);
   assign off_rd  = instruction_i.rd[RF_ADDR_W-1:0];
   assign off_rs  = instruction_i.rs_imm[RF_ADDR_W-1:0];
   assign held_rd = dec_q.rd[RF_ADDR_W-1:0];

   // A load leaves the stage (and starts being tracked) on the output handshake,
   // independent of any flush in the same cycle.
   assign issue_v = full && dec_ready_i && dec_q.is_load;

   cl_scoreboard #(
      .RF_ADDR_W   (RF_ADDR_W),
      .MAX_PENDING (MAX_PENDING)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (n_reset_i),
      .issue_v   (issue_v),
      .issue_rd  (held_rd),
      .retire_v  (load_done_v_i),
      .retire_rd (load_done_rd_i),
      .pending   (pending),
      .count     (pending_cnt_o),
      .retire_ok (retire_ok),
      .err       (err_o)
   );

   assign pend_hit  = pending[off_rs] || pending[off_rd];
   assign stage_hit = full && dec_q.is_load && (held_rd == off_rs || held_rd == off_rd);
   assign hazard_o  = n_reset_i && instr_v_i && (pend_hit || stage_hit);

   // A same-cycle retire frees the slot a new load would otherwise wait for.
   assign cap_block = offered.is_load && (pending_cnt_o == CNT_W'(MAX_PENDING)) && !retire_ok;

   assign instr_ready_o = n_reset_i && !hazard_o && !flush_i
                          && (!full || dec_ready_i) && !cap_block;
   assign accept        = instr_v_i && instr_ready_o;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_EMPTY: if (accept) state_d = S_FULL;
         S_FULL: begin
            if (flush_i)                      state_d = S_EMPTY;
            else if (dec_ready_i && !accept)  state_d = S_EMPTY;
         end
         default: state_d = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge n_reset_i) begin
      if (!n_reset_i) state_q <= S_EMPTY;
      else            state_q <= state_d;
   end

   // The held decode only changes on accept, which keeps it stable under stall.
   always_ff @(posedge clk or negedge n_reset_i) begin
      if (!n_reset_i)  dec_q <= '0;
      else if (accept) dec_q <= offered;
   end

   assign dec_v_o = full;
   assign dec_o   = dec_q;

endmodule

// File: tb/tb_cl_decode_stage.sv
// Directed bench for cl_decode_stage: expected decodes are queued at issue and
// checked by an independent output monitor; status outputs are checked inline.
module tb_cl_decode_stage;
   import cl_decode_stage_pkg::*;

   logic          clk = 1'b0;
   logic          n_reset = 1'b0;
   logic          instr_v = 1'b0;
   instruction_s  instr = '0;
   logic          flush = 1'b0;
   logic          dec_ready = 1'b0;
   logic          ld_v = 1'b0;
   logic [5:0]    ld_rd = '0;
   logic          instr_ready, dec_v, hazard, err;
   decode_s       dec;
   logic [1:0]    cnt;

   logic          instr_v1 = 1'b0;
   instruction_s  instr1 = '0;
   logic          instr_ready1, dec_v1, hazard1, err1;
   decode_s       dec1;
   logic [1:0]    cnt1;

   int            errors = 0;
   int            checks = 0;
   decode_s       exp_q[$];

   always #5 clk = ~clk;

   cl_decode_stage u_dut (
      .clk            (clk),
      .n_reset_i      (n_reset),
      .instr_v_i      (instr_v),
      .instruction_i  (instr),
      .instr_ready_o  (instr_ready),
      .flush_i        (flush),
      .dec_v_o        (dec_v),
      .dec_ready_i    (dec_ready),
      .dec_o          (dec),
      .load_done_v_i  (ld_v),
      .load_done_rd_i (ld_rd),
      .pending_cnt_o  (cnt),
      .hazard_o       (hazard),
      .err_o          (err)
   );

   cl_decode_stage #(.BYTE_OPS_EN(0)) u_dut_nobyte (
      .clk            (clk),
      .n_reset_i      (n_reset),
      .instr_v_i      (instr_v1),
      .instruction_i  (instr1),
      .instr_ready_o  (instr_ready1),
      .flush_i        (1'b0),
      .dec_v_o        (dec_v1),
      .dec_ready_i    (1'b1),
      .dec_o          (dec1),
      .load_done_v_i  (1'b0),
      .load_done_rd_i (6'd0),
      .pending_cnt_o  (cnt1),
      .hazard_o       (hazard1),
      .err_o          (err1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic decode_s mk(input logic ld, input logic wr, input logic st,
                                  input logic mem, input logic by,
                                  input logic [5:0] rd, input logic [5:0] rs);
      decode_s d;
      d.is_load = ld;  d.op_writes_rf = wr; d.is_store = st;
      d.is_mem  = mem; d.is_byte = by;      d.rd = rd; d.rs = rs;
      return d;
   endfunction

   function automatic instruction_s ins(input opcode_e op, input logic [5:0] rd,
                                        input logic [5:0] rs);
      instruction_s i;
      i.opcode = op; i.rd = rd; i.rs_imm = rs;
      return i;
   endfunction

   task automatic drive(input logic v, input instruction_s i, input logic rdy,
                        input logic fl, input logic lv, input logic [5:0] lrd);
      instr_v = v; instr = i; dec_ready = rdy; flush = fl; ld_v = lv; ld_rd = lrd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Output monitor: every valid cycle must show the oldest queued decode.
   initial begin
      forever begin
         @(negedge clk);
         if (n_reset && dec_v) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL dec_o: valid with nothing expected, got %0h", dec);
            end else begin
               check("dec_o", dec, exp_q[0]);
               if (dec_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, with an instruction offered
      drive(1'b1, ins(kADDU, 3, 4), 1'b1, 1'b0, 1'b0, 6'd0);
      @(negedge clk);
      check("rst_ready", instr_ready, 0);
      check("rst_hazard", hazard, 0);
      check("rst_dec_v", dec_v, 0);
      check("rst_dec", dec, 0);
      check("rst_cnt", cnt, 0);
      check("rst_err", err, 0);
      step();
      n_reset = 1'b1;

      // ADDU rd=3 rs=4, and LBU on the byte-ops-disabled instance
      drive(1'b1, ins(kADDU, 3, 4), 1'b1, 1'b0, 1'b0, 6'd0);
      exp_q.push_back(mk(0, 1, 0, 0, 0, 3, 4));
      instr_v1 = 1'b1; instr1 = ins(kLBU, 4, 5);
      @(negedge clk);
      check("addu_ready", instr_ready, 1);
      check("addu_hazard", hazard, 0);
      step();
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 6'd0);
      instr_v1 = 1'b0;
      @(negedge clk);
      check("nb_dec_v", dec_v1, 1);
      check("nb_is_byte", dec1.is_byte, 0);
      check("nb_is_mem", dec1.is_mem, 0);
      check("nb_is_load", dec1.is_load, 0);
      check("nb_rd", dec1.rd, 4);
      step();

      // LW rd=5 handed off, then ADDU rs=5 blocked until the retire
      drive(1'b1, ins(kLW, 5, 0), 1'b1, 1'b0, 1'b0, 6'd0);
      exp_q.push_back(mk(1, 1, 0, 1, 0, 5, 0));
      @(negedge clk);
      check("lw5_ready", instr_ready, 1);
      step();
      drive(1'b1, ins(kADDU, 6, 5), 1'b1, 1'b0, 1'b0, 6'd0);
      @(negedge clk);
      check("use_stage_hazard", hazard, 1);
      check("use_stage_ready", instr_ready, 0);
      step();
      @(negedge clk);
      check("use_pend_hazard", hazard, 1);
      check("use_pend_ready", instr_ready, 0);
      check("use_pend_cnt", cnt, 1);
      step();
      drive(1'b1, ins(kADDU, 6, 5), 1'b1, 1'b0, 1'b1, 6'd5);
      @(negedge clk);
      check("use_retire_hazard", hazard, 1);
      check("use_retire_ready", instr_ready, 0);
      step();
      drive(1'b1, ins(kADDU, 6, 5), 1'b1, 1'b0, 1'b0, 6'd0);
      exp_q.push_back(mk(0, 1, 0, 0, 0, 6, 5));
      @(negedge clk);
      check("use_after_hazard", hazard, 0);
      check("use_after_ready", instr_ready, 1);
      check("use_after_cnt", cnt, 0);
      check("use_after_err", err, 0);
      step();
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 6'd0);
      @(negedge clk);
      step();

      // Two loads in flight, a third blocked until a same-cycle retire
      drive(1'b1, ins(kLW, 1, 0), 1'b1, 1'b0, 1'b0, 6'd0);
      exp_q.push_back(mk(1, 1, 0, 1, 0, 1, 0));
      @(negedge clk);
      check("lw1_ready", instr_ready, 1);
      step();
      drive(1'b1, ins(kLW, 2, 0), 1'b1, 1'b0, 1'b0, 6'd0);
      exp_q.push_back(mk(1, 1, 0, 1, 0, 2, 0));
      @(negedge clk);
      check("lw2_ready", instr_ready, 1);
      step();
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 6'd0);
      @(negedge clk);
      check("lw2_cnt", cnt, 1);
      step();
      drive(1'b1, ins(kLW, 7, 0), 1'b1, 1'b0, 1'b0, 6'd0);
      @(negedge clk);
      check("cap_cnt", cnt, 2);
      check("cap_ready", instr_ready, 0);
      check("cap_hazard", hazard, 0);
      step();
      drive(1'b1, ins(kLW, 7, 0), 1'b1, 1'b0, 1'b1, 6'd1);
      exp_q.push_back(mk(1, 1, 0, 1, 0, 7, 0));
      @(negedge clk);
      check("cap_retire_ready", instr_ready, 1);
      check("cap_retire_cnt", cnt, 2);
      step();
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 6'd0);
      @(negedge clk);
      check("lw7_held_cnt", cnt, 1);
      step();
      @(negedge clk);
      check("lw7_issued_cnt", cnt, 2);
      check("lw7_err", err, 0);
      step();

      // Retire of a register that is not pending
      drive(1'b0, '0, 1'b1, 1'b0, 1'b1, 6'd9);
      @(negedge clk);
      step();
      drive(1'b0, '0, 1'b1, 1'b0, 1'b1, 6'd2);
      @(negedge clk);
      check("bad_retire_err", err, 1);
      check("bad_retire_cnt", cnt, 2);
      step();
      drive(1'b0, '0, 1'b1, 1'b0, 1'b1, 6'd7);
      @(negedge clk);
      check("drain_cnt1", cnt, 1);
      step();
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 6'd0);
      @(negedge clk);
      check("drain_cnt0", cnt, 0);
      check("err_sticky", err, 1);
      step();

      // Stall for three cycles, then flush the held load
      drive(1'b1, ins(kLW, 8, 9), 1'b1, 1'b0, 1'b0, 6'd0);
      exp_q.push_back(mk(1, 1, 0, 1, 0, 8, 9));
      @(negedge clk);
      check("lw8_ready", instr_ready, 1);
      step();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, ins(kADDU, 10, 11), 1'b0, 1'b0, 1'b0, 6'd0);
         @(negedge clk);
         check("stall_ready", instr_ready, 0);
         check("stall_dec_v", dec_v, 1);
         step();
      end
      drive(1'b1, ins(kADDU, 10, 11), 1'b0, 1'b1, 1'b0, 6'd0);
      @(negedge clk);
      check("flush_ready", instr_ready, 0);
      @(posedge clk);
      void'(exp_q.pop_front());
      #1;
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 6'd0);
      @(negedge clk);
      check("flush_dec_v", dec_v, 0);
      check("flush_cnt", cnt, 0);
      step();

      // Flush in the same cycle as a load hand-off still counts the load
      drive(1'b1, ins(kLW, 12, 0), 1'b1, 1'b0, 1'b0, 6'd0);
      exp_q.push_back(mk(1, 1, 0, 1, 0, 12, 0));
      @(negedge clk);
      check("lw12_ready", instr_ready, 1);
      step();
      drive(1'b1, ins(kADDU, 12, 0), 1'b1, 1'b1, 1'b0, 6'd0);
      @(negedge clk);
      check("rd_stage_hazard", hazard, 1);
      check("flush_hs_ready", instr_ready, 0);
      step();
      drive(1'b0, '0, 1'b1, 1'b0, 1'b1, 6'd12);
      @(negedge clk);
      check("flush_hs_dec_v", dec_v, 0);
      check("flush_hs_cnt", cnt, 1);
      step();
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 6'd0);
      @(negedge clk);
      check("lw12_retired_cnt", cnt, 0);
      step();

      // Byte ops enabled: LBU and SB
      drive(1'b1, ins(kLBU, 13, 14), 1'b1, 1'b0, 1'b0, 6'd0);
      exp_q.push_back(mk(1, 1, 0, 1, 1, 13, 14));
      @(negedge clk);
      check("lbu_ready", instr_ready, 1);
      step();
      drive(1'b1, ins(kSB, 15, 16), 1'b1, 1'b0, 1'b0, 6'd0);
      exp_q.push_back(mk(0, 0, 1, 1, 1, 15, 16));
      @(negedge clk);
      check("sb_ready", instr_ready, 1);
      check("sb_hazard", hazard, 0);
      step();
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 6'd0);
      @(negedge clk);
      check("lbu_cnt", cnt, 1);
      step();

      // Reset mid-operation drops the pending load and the sticky error
      drive(1'b1, ins(kADDU, 13, 13), 1'b1, 1'b0, 1'b0, 6'd0);
      @(negedge clk);
      check("pre_reset_hazard", hazard, 1);
      check("queue_drained", exp_q.size(), 0);
      #2;
      n_reset = 1'b0;
      #1;
      check("mid_rst_cnt", cnt, 0);
      check("mid_rst_err", err, 0);
      check("mid_rst_hazard", hazard, 0);
      check("mid_rst_ready", instr_ready, 0);
      step();
      n_reset = 1'b1;
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 6'd0);
      @(negedge clk);
      check("post_rst_cnt", cnt, 0);
      check("post_rst_dec_v", dec_v, 0);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cl_decode_stage.md
CL_DECODE_STAGE -- requirements
Module: cl_decode_stage

Interface
REQ-001 SHALL take parameter RF_ADDR_W, default 6, register-address width.
REQ-002 SHALL take parameter MAX_PENDING, default 2, the maximum number of in-flight loads.
REQ-003 SHALL take parameter BYTE_OPS_EN, default 1; 0 forces is_byte to 0 and treats kLBU/kSB as non-memory ops.
REQ-004 SHALL have port clk, input, 1, the single clock, all state rising-edge.
REQ-005 SHALL have port n_reset_i, input, 1, reset; asynchronous and active-low.
REQ-006 SHALL have port instr_v_i, input, 1, an instruction is offered.
REQ-007 SHALL have port instruction_i, input, instruction_s, the offered instruction (fields rd, rs_imm).
REQ-008 SHALL have port instr_ready_o, output, 1, the stage accepts this cycle.
REQ-009 SHALL have port flush_i, input, 1, discard the held decode.
REQ-010 SHALL have port dec_v_o, output, 1, dec_o is valid.
REQ-011 SHALL have port dec_ready_i, input, 1, downstream consumes dec_o.
REQ-012 SHALL have port dec_o, output, decode_s, fields is_load, op_writes_rf, is_store, is_mem, is_byte, rd, rs.
REQ-013 SHALL have port load_done_v_i, input, 1, a load retired.
REQ-014 SHALL have port load_done_rd_i, input, RF_ADDR_W, the destination of the retired load.
REQ-015 SHALL have port pending_cnt_o, output, $clog2(MAX_PENDING+1), the in-flight load count.
REQ-016 SHALL have port hazard_o, output, 1, the offered instruction is blocked by a load-use hazard.
REQ-017 SHALL have port err_o, output, 1, a sticky protocol error.

Function
REQ-018 SHALL decode with the same opcode classes as the lab3 controller: load kLW/kLBU; store kSW/kSB; mem is load|store; byte kLBU/kSB; rf-write covers the ALU/MOV/JALR/load/NOP set.
REQ-019 SHALL register the decode: an instruction accepted in cycle N appears on dec_o with dec_v_o=1 in cycle N+1 (latency 1).
REQ-020 SHALL use two states: EMPTY (dec_v_o=0) and FULL (dec_v_o=1).
REQ-021 SHALL make these transitions: EMPTY->FULL on accept; FULL->EMPTY on dec_ready_i without a new accept; FULL->FULL on dec_ready_i plus accept, or on hold.
REQ-022 SHALL drive instr_ready_o = !hazard_o && !flush_i && (EMPTY || dec_ready_i) && !(offered is_load && pending_cnt_o==MAX_PENDING && no retire this cycle).
REQ-023 SHALL assert hazard_o when instr_v_i=1 and either rs or rd of the offered instruction matches any of the following:
  - a pending-load bit;
  - dec_o.rd while FULL with dec_o.is_load=1.
REQ-024 SHALL set the pending bit [dec_o.rd] and increment the count when FULL && dec_ready_i && dec_o.is_load.
REQ-025 SHALL, on load_done_v_i with the pending bit [load_done_rd_i] set, clear that bit and decrement the count.
REQ-026 SHALL, on load_done_v_i with the bit clear, change no state and set err_o.
REQ-027 SHALL, when a load issue and a retire occur in the same cycle, apply both; the count is unchanged and the issued bit ends set.
REQ-028 SHALL, on flush_i, go to EMPTY next cycle with dec_v_o=0, accept nothing that cycle, and leave the pending bits/count untouched; a load handed off in the same cycle still counts.
REQ-029 SHALL hold dec_o stable while FULL && !dec_ready_i.
REQ-030 SHALL set err_o if the count would exceed MAX_PENDING or go below 0.
REQ-031 SHALL saturate the count at MAX_PENDING and at 0.

Reset
REQ-032 SHALL, while n_reset_i=0 (asynchronously), clear state to EMPTY, dec_v_o, dec_o, all pending bits, pending_cnt_o and err_o.
REQ-033 SHALL have instr_ready_o=0 and hazard_o=0 during reset.
REQ-034 SHALL, on reset mid-operation, drop all in-flight tracking, with no retire replay.

Structure
REQ-035 SHALL place decode_s and the opcode patterns in the shared definitions package; RF_ADDR_W and MAX_PENDING remain module parameters.
REQ-036 SHALL implement the pending vector, count and err_o in one sub-module, cl_scoreboard.

Verification
REQ-037 SHALL cover ADDU rd=3 rs=4, dec_ready_i=1 -> dec_v_o=1 next cycle with op_writes_rf=1, rd=3, and no hazard.
REQ-038 SHALL cover LW rd=5 handed off, then ADDU rs=5 -> hazard_o=1 and instr_ready_o=0 until load_done_rd_i=5, then accepted the next cycle.
REQ-039 SHALL cover MAX_PENDING=2: LW rd=1 and LW rd=2 issued, then LW rd=7 -> blocked; a retire of rd=1 in the same cycle -> accepted, count stays 2.
REQ-040 SHALL cover load_done_v_i with rd=9 not pending -> err_o=1, count unchanged.
REQ-041 SHALL cover FULL with dec_ready_i=0 for 3 cycles -> dec_o stable; then flush_i -> dec_v_o=0, count unchanged.
REQ-042 SHALL cover BYTE_OPS_EN=0 with LBU -> is_byte=0, is_mem=0, is_load=0.
